// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch front end: one outstanding word read, a DEPTH-entry {pc, word}
// FIFO toward decode, and redirect flush. Define FETCH_BYPASS_EN for same-cycle ack-to-decode bypass.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [29:0] inst_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [29:0]      fetch_pc_q, fetch_pc_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      data_q [DEPTH];
    logic [29:0]      pc_q   [DEPTH];

    logic             fifo_valid_s;
    logic             pop_s;
    logic             push_s;
    logic             bypass_s;
    logic             bypass_take_s;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W-1:0] count_pop_s;
    logic [PTR_W-1:0] head_idx_s;

    assign fifo_valid_s  = (wr_ptr_q != rd_ptr_q);
    assign count_s       = wr_ptr_q - rd_ptr_q;
    assign pop_s         = fifo_valid_s & inst_ready & ~redirect;
    assign count_pop_s   = count_s - {{PTR_W{1'b0}}, pop_s};
    assign head_idx_s    = rd_ptr_q[PTR_W-1:0];

`ifdef FETCH_BYPASS_EN
    assign bypass_s      = ~fifo_valid_s & (state_q == ST_WAIT) & mem_ack & ~redirect;
`else
    assign bypass_s      = 1'b0;
`endif
    assign bypass_take_s = bypass_s & inst_ready;

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    // Decode-facing head: FIFO registers, or the live response when bypassing.
    always_comb begin
        inst_valid  = fifo_valid_s | bypass_s;
        if (bypass_s) begin
            instruction = mem_rdata;
            inst_pc     = fetch_pc_q;
        end else begin
            instruction = data_q[head_idx_s];
            inst_pc     = pc_q[head_idx_s];
        end
    end

    // Fetch sequencer: request issue, response accept/drop, redirect handling.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (count_pop_s < DEPTH_C) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {fetch_pc_q, 2'b00};
                    state_d    = ST_WAIT;
                end else begin
                    mem_req_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d   = ST_DISCARD;
                    end
                end else if (mem_ack) begin
                    push_s     = ~bypass_take_s;
                    fetch_pc_d = fetch_pc_q + 30'd1;
                    if ((count_pop_s + {{PTR_W{1'b0}}, push_s}) < DEPTH_C) begin
                        mem_addr_d = {fetch_pc_q + 30'd1, 2'b00};
                    end else begin
                        mem_req_d  = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                // The stale request cannot be withdrawn; its response is dropped.
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d   = ST_DISCARD;
                    end
                end else if (mem_ack) begin
                    if (count_pop_s < DEPTH_C) begin
                        mem_addr_d = {fetch_pc_q, 2'b00};
                        state_d    = ST_WAIT;
                    end else begin
                        mem_req_d  = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer next-state; redirect flushes everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push_s};
            rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop_s};
        end
    end

    // Sequencer and request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= 32'h0;
                pc_q[i]   <= 30'h0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_s) begin
                data_q[wr_ptr_q[PTR_W-1:0]] <= mem_rdata;
                pc_q[wr_ptr_q[PTR_W-1:0]]   <= fetch_pc_q;
            end else begin
                data_q[wr_ptr_q[PTR_W-1:0]] <= data_q[wr_ptr_q[PTR_W-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: memory responder, decode-side monitor, directed tests.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [29:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [29:0] inst_pc;

    int total = 0;
    int bad   = 0;

    int          ack_delay    = 1;
    int          acks_granted = 0;
    int          acks_done    = 0;
    int          wait_cnt     = 0;
    int          base         = 0;
    logic [31:0] ack_log [0:63];

    logic [29:0] exp_pc [0:63];
    int          exp_wr = 0;
    int          exp_rd = 0;

    fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(30'h0)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .instruction(instruction), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [29:0] pc);
        return {pc, 2'b00} ^ 32'hA5C3_0F96;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [29:0] pc);
        exp_pc[exp_wr] = pc;
        exp_wr++;
    endtask

    task automatic start_test(input int dly, input logic rdy, input int n);
        @(posedge clk); #1;
        reset      = 1'b1;
        redirect   = 1'b0;
        inst_ready = rdy;
        ack_delay  = dly;
        chk("sb_drain", exp_rd, exp_wr);
        base         = acks_done;
        acks_granted = acks_done + n;
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_ack) break;
        end
        chk(name, {31'b0, mem_ack}, 32'd1);
    endtask

    task automatic wait_sb(input string name);
        for (int i = 0; i < 100 && exp_rd != exp_wr; i++) @(negedge clk);
        chk(name, exp_rd, exp_wr);
    endtask

    // Memory responder: acks the held request after ack_delay cycles, within the grant budget.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (reset || !mem_req) begin
                wait_cnt = 0;
            end else if (acks_done < acks_granted) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = word_of(mem_addr[31:2]);
                    ack_log[acks_done] = mem_addr;
                    acks_done++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Decode-side monitor: every accepted instruction is checked against the expected stream.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && inst_valid && inst_ready && !redirect) begin
                if (exp_rd >= exp_wr) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got pc %h word %h, expected nothing", inst_pc, instruction);
                end else begin
                    chk("sb_pc", {2'b00, inst_pc}, {2'b00, exp_pc[exp_rd]});
                    chk("sb_word", instruction, word_of(exp_pc[exp_rd]));
                    exp_rd++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 30'h0;
        inst_ready  = 1'b0;
        @(negedge clk);
        chk("rst_req",   {31'b0, mem_req},    32'd0);
        chk("rst_addr",  mem_addr,            32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_instr", instruction,         32'h0);
        chk("rst_pc",    {2'b00, inst_pc},    32'h0);

        // Streaming from RESET_PC with ready decode and 1-cycle memory.
        start_test(1, 1'b1, 3);
        push_exp(30'd0); push_exp(30'd1); push_exp(30'd2);
        release_reset();
        @(negedge clk);
        chk("t1_no_req_first", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        chk("t1_req", {31'b0, mem_req}, 32'd1);
        chk("t1_addr0", mem_addr, 32'h0);
        wait_ack("t1_ack_seen");
`ifdef FETCH_BYPASS_EN
        chk("t1_lat_valid", {31'b0, inst_valid}, 32'd1);
        chk("t1_lat_pc", {2'b00, inst_pc}, 32'h0);
`else
        chk("t1_lat_ack_cycle", {31'b0, inst_valid}, 32'd0);
        @(negedge clk);
        chk("t1_lat_valid", {31'b0, inst_valid}, 32'd1);
        chk("t1_lat_pc", {2'b00, inst_pc}, 32'h0);
        chk("t1_lat_word", instruction, word_of(30'd0));
`endif
        wait_sb("t1_drain");
        chk("t1_addr_a", ack_log[base],     32'h0);
        chk("t1_addr_b", ack_log[base + 1], 32'h4);
        chk("t1_addr_c", ack_log[base + 2], 32'h8);

        // Decode stalled: fill to DEPTH, then resume after the first pop.
        start_test(1, 1'b0, 8);
        for (int i = 0; i < 8; i++) push_exp(30'(i));
        release_reset();
        repeat (20) @(negedge clk);
        chk("t2_acks_full", acks_done - base, 32'd4);
        chk("t2_req_low", {31'b0, mem_req}, 32'd0);
        chk("t2_valid", {31'b0, inst_valid}, 32'd1);
        chk("t2_head_pc", {2'b00, inst_pc}, 32'h0);
        @(posedge clk); #1;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("t2_req_at_pop", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        chk("t2_resume_req", {31'b0, mem_req}, 32'd1);
        chk("t2_resume_addr", mem_addr, 32'h10);
        wait_sb("t2_drain");
        chk("t2_addr_last", ack_log[base + 7], 32'h1C);

        // Redirect while a slow request is outstanding.
        start_test(3, 1'b1, 4);
        push_exp(30'h40); push_exp(30'h41); push_exp(30'h42);
        release_reset();
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 30'h40;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("t3_held_req", {31'b0, mem_req}, 32'd1);
        chk("t3_held_addr", mem_addr, 32'h0);
        chk("t3_no_valid", {31'b0, inst_valid}, 32'd0);
        wait_sb("t3_drain");
        chk("t3_dropped_addr", ack_log[base],     32'h0);
        chk("t3_target_addr",  ack_log[base + 1], 32'h100);
        chk("t3_next_addr",    ack_log[base + 2], 32'h104);

        // Redirect, ack and pop in one cycle; target wraps the 30-bit PC.
        start_test(0, 1'b1, 6);
        push_exp(30'd0);
`ifdef FETCH_BYPASS_EN
        push_exp(30'd1);
`endif
        push_exp(30'h3FFF_FFFF); push_exp(30'd0); push_exp(30'd1);
        release_reset();
        wait_ack("t4_ack_seen");
        @(posedge clk); #1;
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 30'h3FFF_FFFF;
        @(negedge clk);
        chk("t4_coinc_ack", {31'b0, mem_ack}, 32'd1);
`ifdef FETCH_BYPASS_EN
        chk("t4_coinc_valid", {31'b0, inst_valid}, 32'd0);
`else
        chk("t4_coinc_valid", {31'b0, inst_valid}, 32'd1);
`endif
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("t4_flushed", {31'b0, inst_valid}, 32'd0);
        @(negedge clk);
        chk("t4_target_req", {31'b0, mem_req}, 32'd1);
        chk("t4_target_addr", mem_addr, 32'hFFFF_FFFC);
        wait_sb("t4_drain");
        chk("t4_wrap_a", ack_log[base + 3], 32'hFFFF_FFFC);
        chk("t4_wrap_b", ack_log[base + 4], 32'h0);
        chk("t4_wrap_c", ack_log[base + 5], 32'h4);

        // Asynchronous reset in the middle of a WAIT with buffered data.
        start_test(1, 1'b0, 2);
        release_reset();
        for (int i = 0; i < 20 && acks_done != base + 2; i++) @(negedge clk);
        @(negedge clk);
        chk("t6_pre_req", {31'b0, mem_req}, 32'd1);
        chk("t6_pre_valid", {31'b0, inst_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_req", {31'b0, mem_req}, 32'd0);
        chk("t6_valid", {31'b0, inst_valid}, 32'd0);
        chk("t6_addr", mem_addr, 32'h0);
        chk("t6_instr", instruction, 32'h0);
        chk("t6_pc", {2'b00, inst_pc}, 32'h0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
